eca_multi_rule_engine: RTL and testbench
========================================

// Module: eca_multi_rule_engine
// PURPOSE
//  Parametrised elementary cellular-automaton core, successor to the fixed rule-110 design.
//  Holds a WIDTH-cell row, applies any of the 256 Wolfram rules with selectable boundary mode,
//  and supports serial row load, free-run / single-step / generation-limited evolution with
//  stable-row auto-halt. An 8-cell output window is exposed for the chip's dedicated outputs.
// PARAMETERS
//  WIDTH        64   cells in the row; multiple of 8, 8..256
//  DEFAULT_RULE 110  rule register value after reset
//  GEN_W        16   width of generation counter and generation limit
// PORTS
//  clk          in   1       clock; all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  ena          in   1       global enable; 0 freezes all state, except that rst still acts
//  rule_wr      in   1       load rule_in into rule register (IDLE only)
//  rule_in      in   8       rule number; bit k = next state for neighbourhood k={L,C,R}
//  bmode        in   2       boundary: 00 wrap, 01 zeros, 10 ones, 11 reflect (edge cell mirrors itself)
//  load_en      in   1       shift load_bit into row (IDLE only)
//  load_bit     in   1       serial cell data
//  cmd          in   2       00 none, 01 run, 10 step, 11 stop
//  gen_limit    in   GEN_W   auto-halt after this many generations; 0 = unlimited
//  win_sel      in   clog2(WIDTH/8)  window byte index
//  win_out      out  8       cells[8*win_sel +: 8], registered
//  gen_count    out  GEN_W   generations computed since last load/clear
//  busy         out  1       1 while in RUN
//  stable       out  1       last generation equal to previous row
// BEHAVIOUR
//  Reset: cells=0, rule=DEFAULT_RULE, state=IDLE, win_out=0, gen_count=0, busy=0, stable=0.
//  Neighbourhood of cell i: L=cells[i+1], C=cells[i], R=cells[i-1]; next[i]=rule[{L,C,R}].
//  Edge cells: i=WIDTH-1 needs L, i=0 needs R. wrap: L=cells[0], R=cells[WIDTH-1];
//   zeros: 0; ones: 1; reflect: L=cells[WIDTH-1], R=cells[0].
//  All cells update simultaneously from the pre-edge row (no partial updates).
//  States: IDLE, RUN, STEP.
//   IDLE: rule_wr and load_en honoured. A load_en cycle shifts the row right:
//    cells <= {load_bit, cells[WIDTH-1:1]}. Every load_en cycle clears gen_count and stable.
//    cmd=01 -> RUN; cmd=10 -> STEP. If rule_wr/load_en coincide with cmd, the write/shift
//    applies this cycle and the new state starts next cycle.
//   STEP: compute one generation, gen_count+1, return to IDLE (1-cycle step).
//   RUN: one generation per enabled cycle. Exit to IDLE after the edge where the count
//    reaches gen_limit (gen_limit!=0), where stable is set, or on cmd=11.
//    cmd=11 takes priority: no generation is computed on that cycle.
//   rule_wr, load_en, cmd=01 and cmd=10 are ignored outside IDLE; cmd=11 in IDLE is a no-op.
//  stable <= (next row == current row), updated on every computed generation.
//  gen_count saturates at all-ones and never wraps; saturation does not halt the engine.
//  win_out: 1-cycle latency from win_sel/cells; reflects the row after the latest update.
//  busy = (state==RUN), combinational from state.
//  rst asserted mid-RUN: immediate return to reset values; the row is lost.
// TESTING
//  T1 WIDTH=64, rule 110, bmode=01, load cell0=1 only, step x3 -> win_out(sel0)=0x03,0x07,0x0D.
//  T2 rule 90 (rule_wr 0x5A), bmode=00, WIDTH=8 param, cell7=1 -> step1 row=0x41 (cells 0,6 set via wrap).
//  T3 rule 204 (identity), run, gen_limit=0 -> halts after 1 gen, stable=1, busy=0, gen_count=1.
//  T4 rule 110 run with gen_limit=5 -> busy exactly 5 cycles, gen_count=5, then IDLE.
//  T5 run, cmd=11 on 3rd RUN cycle -> gen_count=2, row equals 2-generation result.
//  T6 rst pulse mid-RUN -> all outputs 0 next cycle, rule back to 110; load_en during RUN ignored.

Source files
------------

// File: rtl/eca_multi_rule_engine_if.sv
// Control/observation bundle for the multi-rule elementary cellular-automaton engine.
interface eca_multi_rule_engine_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned GEN_W = 16
);
    localparam int unsigned SEL_W = (WIDTH > 8) ? $clog2(WIDTH / 8) : 1;

    logic             ena;
    logic             rule_wr;
    logic [7:0]       rule_in;
    logic [1:0]       bmode;
    logic             load_en;
    logic             load_bit;
    logic [1:0]       cmd;
    logic [GEN_W-1:0] gen_limit;
    logic [SEL_W-1:0] win_sel;
    logic [7:0]       win_out;
    logic [GEN_W-1:0] gen_count;
    logic             busy;
    logic             stable;

    modport master (
        output ena, rule_wr, rule_in, bmode, load_en, load_bit, cmd, gen_limit, win_sel,
        input  win_out, gen_count, busy, stable
    );

    modport slave (
        input  ena, rule_wr, rule_in, bmode, load_en, load_bit, cmd, gen_limit, win_sel,
        output win_out, gen_count, busy, stable
    );
endinterface

// File: rtl/eca_multi_rule_engine.sv
// Elementary cellular automaton: WIDTH-cell row, any Wolfram rule, four boundary modes,
// serial load, free-run / single-step / generation-limited evolution with stable-row halt.
module eca_multi_rule_engine #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned DEFAULT_RULE = 110,
    parameter int unsigned GEN_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    eca_multi_rule_engine_if.slave      bus
);
    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned SEL_W  = (WIDTH > 8) ? $clog2(WIDTH / 8) : 1;

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    localparam logic [1:0] BM_WRAP    = 2'b00;
    localparam logic [1:0] BM_ZEROS   = 2'b01;
    localparam logic [1:0] BM_ONES    = 2'b10;
    localparam logic [1:0] BM_REFLECT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cells_q, cells_d;
    logic [7:0]       rule_q, rule_d;
    logic [7:0]       win_out_q, win_out_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             stable_q, stable_d;

    logic [WIDTH-1:0] next_row;
    logic [WIDTH+1:0] ext;
    logic             edge_l, edge_r;
    logic [GEN_W-1:0] gen_inc;
    logic             row_same;
    logic             do_gen;

    // Next generation of the whole row: pad with boundary neighbours, then rule lookup per cell.
    always_comb begin
        edge_l = 1'b0;
        edge_r = 1'b0;
        case (bus.bmode)
            BM_WRAP: begin
                edge_l = cells_q[0];
                edge_r = cells_q[WIDTH-1];
            end
            BM_ZEROS: begin
                edge_l = 1'b0;
                edge_r = 1'b0;
            end
            BM_ONES: begin
                edge_l = 1'b1;
                edge_r = 1'b1;
            end
            BM_REFLECT: begin
                edge_l = cells_q[WIDTH-1];
                edge_r = cells_q[0];
            end
            default: begin
                edge_l = 1'b0;
                edge_r = 1'b0;
            end
        endcase
        ext = {edge_l, cells_q, edge_r};
        for (int i = 0; i < int'(WIDTH); i++) begin
            next_row[i] = rule_q[ext[i +: 3]];
        end
    end

    // Saturating generation increment and stability test.
    always_comb begin
        gen_inc  = (&gen_q) ? gen_q : gen_q + GEN_W'(1);
        row_same = (next_row == cells_q);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cells_d   = cells_q;
        rule_d    = rule_q;
        gen_d     = gen_q;
        stable_d  = stable_q;
        win_out_d = win_out_q;
        do_gen    = 1'b0;
        if (bus.ena) begin
            case (state_q)
                IDLE: begin
                    if (bus.rule_wr) begin
                        rule_d = bus.rule_in;
                    end
                    if (bus.load_en) begin
                        cells_d  = {bus.load_bit, cells_q[WIDTH-1:1]};
                        gen_d    = '0;
                        stable_d = 1'b0;
                    end
                    if (bus.cmd == CMD_RUN) begin
                        state_d = RUN;
                    end else if (bus.cmd == CMD_STEP) begin
                        state_d = STEP;
                    end
                end
                STEP: begin
                    do_gen  = 1'b1;
                    state_d = IDLE;
                end
                RUN: begin
                    if (bus.cmd == CMD_STOP) begin
                        state_d = IDLE;
                    end else begin
                        do_gen = 1'b1;
                        if (row_same || ((bus.gen_limit != '0) && (gen_inc == bus.gen_limit))) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (do_gen) begin
                cells_d  = next_row;
                gen_d    = gen_inc;
                stable_d = row_same;
            end

            win_out_d = '0;
            for (int b = 0; b < int'(NBYTES); b++) begin
                if (bus.win_sel == SEL_W'(b)) begin
                    win_out_d = cells_q[8*b +: 8];
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cells_q   <= '0;
            rule_q    <= 8'(DEFAULT_RULE);
            gen_q     <= '0;
            stable_q  <= 1'b0;
            win_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cells_q   <= cells_d;
            rule_q    <= rule_d;
            gen_q     <= gen_d;
            stable_q  <= stable_d;
            win_out_q <= win_out_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.win_out   = win_out_q;
    assign bus.gen_count = gen_q;
    assign bus.stable    = stable_q;
endmodule

// File: tb/tb_eca_multi_rule_engine.sv
// Self-checking bench for eca_multi_rule_engine: vector table, directed corner sequences,
// and randomized evolution compared against a rule-lookup reference model.
module tb_eca_multi_rule_engine;
    localparam int unsigned W   = 64;
    localparam int unsigned GW  = 16;
    localparam int unsigned W8  = 8;
    localparam int unsigned GW8 = 4;
    localparam int GMAX = (1 << GW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    eca_multi_rule_engine_if #(.WIDTH(W),  .GEN_W(GW))  bus  ();
    eca_multi_rule_engine_if #(.WIDTH(W8), .GEN_W(GW8)) bus8 ();

    eca_multi_rule_engine #(.WIDTH(W), .DEFAULT_RULE(110), .GEN_W(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    eca_multi_rule_engine #(.WIDTH(W8), .DEFAULT_RULE(110), .GEN_W(GW8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    int checks = 0;
    int errors = 0;

    // reference model state for the 64-cell instance
    logic [63:0] m_row;
    logic [7:0]  m_rule;
    int          m_gen;
    bit          m_stable;
    bit          m_busy;

    typedef struct {
        logic [7:0]  rule;
        logic [1:0]  bm;
        logic [63:0] row;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rule applied literally: neighbourhood index L*4+C*2+R selects a bit of the rule number.
    function automatic logic [63:0] model_next(input logic [63:0] row, input logic [7:0] rule,
                                               input logic [1:0] bm);
        logic [63:0] nxt;
        int l, c, r;
        nxt = '0;
        for (int i = 0; i < int'(W); i++) begin
            c = int'(row[i]);
            if (i == int'(W) - 1) begin
                case (bm)
                    2'b00:   l = int'(row[0]);
                    2'b01:   l = 0;
                    2'b10:   l = 1;
                    default: l = int'(row[W-1]);
                endcase
            end else begin
                l = int'(row[i+1]);
            end
            if (i == 0) begin
                case (bm)
                    2'b00:   r = int'(row[W-1]);
                    2'b01:   r = 0;
                    2'b10:   r = 1;
                    default: r = int'(row[0]);
                endcase
            end else begin
                r = int'(row[i-1]);
            end
            nxt[i] = rule[l*4 + c*2 + r];
        end
        return nxt;
    endfunction

    task automatic model_gen();
        logic [63:0] nxt;
        nxt      = model_next(m_row, m_rule, bus.bmode);
        m_stable = (nxt == m_row);
        m_row    = nxt;
        if (m_gen < GMAX) m_gen++;
    endtask

    task automatic write_rule(input logic [7:0] r);
        bus.rule_wr = 1'b1;
        bus.rule_in = r;
        tick();
        bus.rule_wr = 1'b0;
        m_rule = r;
    endtask

    task automatic load_row(input logic [63:0] row);
        for (int k = 0; k < int'(W); k++) begin
            bus.load_en  = 1'b1;
            bus.load_bit = row[k];
            tick();
        end
        bus.load_en  = 1'b0;
        bus.load_bit = 1'b0;
        m_row    = row;
        m_gen    = 0;
        m_stable = 1'b0;
    endtask

    task automatic do_step();
        bus.cmd = 2'b10;
        tick();
        bus.cmd = 2'b00;
        tick();
        model_gen();
    endtask

    task automatic read_row(output logic [63:0] row);
        row = '0;
        for (int b = 0; b < int'(W / 8); b++) begin
            bus.win_sel = 3'(b);
            tick();
            row[8*b +: 8] = bus.win_out;
        end
        bus.win_sel = '0;
    endtask

    task automatic check_state(input string tag);
        logic [63:0] row;
        read_row(row);
        check({tag, "_row"},    row, m_row);
        check({tag, "_gen"},    64'(bus.gen_count), 64'(m_gen));
        check({tag, "_stable"}, 64'(bus.stable), 64'(m_stable));
        check({tag, "_busy"},   64'(bus.busy), 64'(0));
    endtask

    // Start a run and follow it cycle by cycle; stop_at counts enabled RUN cycles (0 = never).
    task automatic do_run(input int limit, input int stop_at, input bit ena_rand);
        int en_cyc;
        int guard;
        bit en;
        bit stop;
        en_cyc = 0;
        guard  = 0;
        bus.gen_limit = GW'(limit);
        bus.cmd = 2'b01;
        tick();
        bus.cmd = 2'b00;
        m_busy = 1'b1;
        check("run_entry_busy", 64'(bus.busy), 64'(1));
        while (m_busy && guard < 500) begin
            en   = ena_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            stop = en && (en_cyc + 1 == stop_at);
            bus.ena = en;
            bus.cmd = stop ? 2'b11 : 2'b00;
            tick();
            if (en) begin
                en_cyc++;
                if (stop) begin
                    m_busy = 1'b0;
                end else begin
                    model_gen();
                    if ((limit != 0 && m_gen == limit) || m_stable) m_busy = 1'b0;
                end
            end
            check("run_busy", 64'(bus.busy), 64'(m_busy));
            guard++;
        end
        bus.ena = 1'b1;
        bus.cmd = 2'b00;
        check("run_end_busy", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        logic [63:0] row;
        logic [7:0]  row8;
        int          busy_cnt;
        int          lim, stp;

        rst           = 1'b1;
        bus.ena       = 1'b1;
        bus.rule_wr   = 1'b0;
        bus.rule_in   = '0;
        bus.bmode     = 2'b01;
        bus.load_en   = 1'b0;
        bus.load_bit  = 1'b0;
        bus.cmd       = 2'b00;
        bus.gen_limit = '0;
        bus.win_sel   = '0;
        bus8.ena       = 1'b1;
        bus8.rule_wr   = 1'b0;
        bus8.rule_in   = '0;
        bus8.bmode     = 2'b00;
        bus8.load_en   = 1'b0;
        bus8.load_bit  = 1'b0;
        bus8.cmd       = 2'b00;
        bus8.gen_limit = '0;
        bus8.win_sel   = '0;
        m_rule = 8'd110;

        tbl[0] = '{rule: 8'd110, bm: 2'b01, row: 64'h1,                   exp: 64'h3};
        tbl[1] = '{rule: 8'd204, bm: 2'b00, row: 64'hDEADBEEF_01234567,   exp: 64'hDEADBEEF_01234567};
        tbl[2] = '{rule: 8'd51,  bm: 2'b01, row: 64'h0,                   exp: 64'hFFFFFFFF_FFFFFFFF};
        tbl[3] = '{rule: 8'd90,  bm: 2'b00, row: 64'h80000000_00000000,   exp: 64'h40000000_00000001};
        tbl[4] = '{rule: 8'd90,  bm: 2'b10, row: 64'h0,                   exp: 64'h80000000_00000001};
        tbl[5] = '{rule: 8'd90,  bm: 2'b11, row: 64'h1,                   exp: 64'h3};
        tbl[6] = '{rule: 8'd170, bm: 2'b01, row: 64'h80000000_00000001,   exp: 64'h2};
        tbl[7] = '{rule: 8'd240, bm: 2'b00, row: 64'h1,                   exp: 64'h80000000_00000000};
        tbl[8] = '{rule: 8'd0,   bm: 2'b10, row: 64'hFFFFFFFF_FFFFFFFF,   exp: 64'h0};

        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset values
        check("rst_win_out", 64'(bus.win_out), 64'(0));
        check("rst_gen",     64'(bus.gen_count), 64'(0));
        check("rst_busy",    64'(bus.busy), 64'(0));
        check("rst_stable",  64'(bus.stable), 64'(0));

        // default rule 110, zero boundaries, single cell, three steps
        bus.bmode = 2'b01;
        load_row(64'h1);
        do_step();
        tick();
        check("t1_step1", 64'(bus.win_out), 64'h03);
        do_step();
        tick();
        check("t1_step2", 64'(bus.win_out), 64'h07);
        do_step();
        tick();
        check("t1_step3", 64'(bus.win_out), 64'h0D);
        check("t1_gen",   64'(bus.gen_count), 64'(3));

        // 8-cell instance: rule 90 with wrap
        bus8.rule_wr = 1'b1;
        bus8.rule_in = 8'h5A;
        tick();
        bus8.rule_wr = 1'b0;
        row8 = 8'h80;
        for (int k = 0; k < int'(W8); k++) begin
            bus8.load_en  = 1'b1;
            bus8.load_bit = row8[k];
            tick();
        end
        bus8.load_en = 1'b0;
        bus8.cmd = 2'b10;
        tick();
        bus8.cmd = 2'b00;
        tick();
        tick();
        check("t2_row",   64'(bus8.win_out), 64'h41);
        check("t2_gen",   64'(bus8.gen_count), 64'(1));

        // 8-cell instance: rule 51 never settles; 4-bit counter saturates at 15
        bus8.rule_wr = 1'b1;
        bus8.rule_in = 8'd51;
        tick();
        bus8.rule_wr   = 1'b0;
        bus8.gen_limit = '0;
        bus8.cmd = 2'b01;
        tick();
        bus8.cmd = 2'b00;
        for (int k = 0; k < 20; k++) tick();
        check("sat_busy_running", 64'(bus8.busy), 64'(1));
        check("sat_gen",          64'(bus8.gen_count), 64'(15));
        bus8.cmd = 2'b11;
        tick();
        bus8.cmd = 2'b00;
        tick();
        check("sat_stop_busy", 64'(bus8.busy), 64'(0));
        check("sat_row",       64'(bus8.win_out), 64'h41);
        check("sat_gen_hold",  64'(bus8.gen_count), 64'(15));

        // vector table: one step each
        for (int t = 0; t < 9; t++) begin
            write_rule(tbl[t].rule);
            bus.bmode = tbl[t].bm;
            load_row(tbl[t].row);
            do_step();
            read_row(row);
            check($sformatf("vec%0d_row", t),    row, tbl[t].exp);
            check($sformatf("vec%0d_gen", t),    64'(bus.gen_count), 64'(1));
            check($sformatf("vec%0d_stable", t), 64'(bus.stable), 64'(tbl[t].exp == tbl[t].row));
        end

        // identity rule with unlimited run halts on the first (stable) generation
        write_rule(8'd204);
        bus.bmode = 2'b00;
        load_row({$urandom(), $urandom()});
        do_run(0, 0, 1'b0);
        check("t3_gen",    64'(bus.gen_count), 64'(1));
        check("t3_stable", 64'(bus.stable), 64'(1));
        check("t3_busy",   64'(bus.busy), 64'(0));
        check_state("t3");

        // generation limit 5: busy for exactly five cycles
        write_rule(8'd110);
        bus.bmode = 2'b01;
        load_row(64'h1);
        bus.gen_limit = GW'(5);
        bus.cmd = 2'b01;
        tick();
        bus.cmd = 2'b00;
        busy_cnt = 0;
        while (bus.busy && busy_cnt < 50) begin
            busy_cnt++;
            tick();
        end
        for (int g = 0; g < 5; g++) model_gen();
        check("t4_busy_cycles", 64'(busy_cnt), 64'(5));
        check("t4_gen",         64'(bus.gen_count), 64'(5));
        check_state("t4");

        // stop on the third RUN cycle
        load_row(64'h1);
        do_run(0, 3, 1'b0);
        check("t5_gen", 64'(bus.gen_count), 64'(2));
        check_state("t5");

        // load/rule writes during RUN are ignored
        write_rule(8'd51);
        row = 64'hA5A5_0F0F_1234_8001;
        load_row(row);
        bus.gen_limit = GW'(4);
        bus.cmd = 2'b01;
        tick();
        bus.cmd      = 2'b00;
        bus.load_en  = 1'b1;
        bus.load_bit = 1'b1;
        bus.rule_wr  = 1'b1;
        bus.rule_in  = 8'd0;
        busy_cnt = 0;
        while (bus.busy && busy_cnt < 50) begin
            busy_cnt++;
            tick();
        end
        bus.load_en  = 1'b0;
        bus.load_bit = 1'b0;
        bus.rule_wr  = 1'b0;
        for (int g = 0; g < 4; g++) model_gen();
        check("ign_row_model", m_row, row);
        check_state("ign");
        do_step();
        check_state("ign_rule_kept");

        // random evolution against the model
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 2) != 0) write_rule(8'($urandom_range(0, 255)));
            bus.bmode = 2'($urandom_range(0, 3));
            load_row({$urandom(), $urandom()});
            if ($urandom_range(0, 2) == 0) begin
                do_step();
            end else begin
                lim = int'($urandom_range(0, 20));
                if (lim == 0) stp = int'($urandom_range(1, 30));
                else stp = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 25)) : 0;
                do_run(lim, stp, $urandom_range(0, 1) != 0);
            end
            check_state($sformatf("rnd%0d", it));
        end

        // reset mid-RUN: outputs clear, rule returns to 110
        write_rule(8'd51);
        load_row(64'h0123_4567_89AB_CDEF);
        bus.gen_limit = '0;
        bus.cmd = 2'b01;
        tick();
        bus.cmd = 2'b00;
        tick();
        tick();
        check("t6_busy_before", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        tick();
        check("t6_win_out", 64'(bus.win_out), 64'(0));
        check("t6_gen",     64'(bus.gen_count), 64'(0));
        check("t6_busy",    64'(bus.busy), 64'(0));
        check("t6_stable",  64'(bus.stable), 64'(0));
        rst = 1'b0;
        tick();
        m_rule = 8'd110;
        m_row  = '0;
        read_row(row);
        check("t6_row_cleared", row, 64'h0);
        bus.bmode = 2'b01;
        load_row(64'h1);
        do_step();
        tick();
        check("t6_rule_default", 64'(bus.win_out), 64'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
